// File: rtl/mod_inv.sv
// Modular inverse R = A^-1 mod P using a binary extended Euclidean engine.
// Multi-cycle start/done handshake; err flags A == 0 mod P or a watchdog expiry.
module mod_inv #(
  parameter logic [255:0] P          = 256'hFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFEFFFFFC2F,
  parameter int           MAX_CYCLES = 1100
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [255:0] A,
  output logic [255:0] R,
  output logic         done,
  output logic         busy,
  output logic         err
);

  localparam int DATA_W = 256;
  localparam int CNT_W  = $clog2(MAX_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE,
    REDUCE,
    LOOP,
    FINISH
  } state_t;

  state_t              state;
  logic [DATA_W-1:0]   u;
  logic [DATA_W-1:0]   v;
  logic [DATA_W-1:0]   x1;
  logic [DATA_W-1:0]   x2;
  logic [CNT_W-1:0]    cnt;

  // x/2 mod P: odd values are made even by adding the odd modulus first.
  function automatic logic [DATA_W-1:0] half_mod(input logic [DATA_W-1:0] x);
    logic [DATA_W:0] s;
    s = x[0] ? ({1'b0, x} + {1'b0, P}) : {1'b0, x};
    return s[DATA_W:1];
  endfunction

  // (a - b) mod P for a, b < P; a borrow is repaired by adding P back.
  function automatic logic [DATA_W-1:0] sub_mod(input logic [DATA_W-1:0] a,
                                                 input logic [DATA_W-1:0] b);
    logic [DATA_W:0] d;
    d = {1'b0, a} - {1'b0, b};
    return d[DATA_W] ? (d[DATA_W-1:0] + P) : d[DATA_W-1:0];
  endfunction

  logic [DATA_W:0]   u_minus_p;
  logic [DATA_W-1:0] u_red;
  logic [DATA_W:0]   u_minus_v;
  logic              u_ge_v;
  logic              u_is_one;
  logic              v_is_one;

  always_comb begin
    u_minus_p = {1'b0, u} - {1'b0, P};
    u_red     = u_minus_p[DATA_W] ? u : u_minus_p[DATA_W-1:0];
    u_minus_v = {1'b0, u} - {1'b0, v};
    u_ge_v    = ~u_minus_v[DATA_W];
    u_is_one  = (u == DATA_W'(1));
    v_is_one  = (v == DATA_W'(1));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      u     <= '0;
      v     <= '0;
      x1    <= '0;
      x2    <= '0;
      cnt   <= '0;
      R     <= '0;
      done  <= 1'b0;
      busy  <= 1'b0;
      err   <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          // A start coinciding with the done pulse is deliberately dropped.
          if (start && !done) begin
            u     <= A;
            v     <= P;
            x1    <= DATA_W'(1);
            x2    <= '0;
            cnt   <= '0;
            err   <= 1'b0;
            busy  <= 1'b1;
            state <= REDUCE;
          end
        end

        REDUCE: begin
          u <= u_red;
          if (u_red == '0) begin
            err   <= 1'b1;
            state <= FINISH;
          end else begin
            state <= LOOP;
          end
        end

        LOOP: begin
          cnt <= cnt + CNT_W'(1);
          if (u_is_one || v_is_one) begin
            // The answer is parked in x1 so FINISH has a single source.
            if (!u_is_one) x1 <= x2;
            state <= FINISH;
          end else if (!u[0]) begin
            u  <= u >> 1;
            x1 <= half_mod(x1);
          end else if (!v[0]) begin
            v  <= v >> 1;
            x2 <= half_mod(x2);
          end else if (u_ge_v) begin
            u  <= u_minus_v[DATA_W-1:0];
            x1 <= sub_mod(x1, x2);
          end else begin
            v  <= v - u;
            x2 <= sub_mod(x2, x1);
          end
          if (cnt == CNT_LAST) begin
            err   <= 1'b1;
            state <= FINISH;
          end
        end

        FINISH: begin
          R     <= err ? '0 : x1;
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mod_inv.sv
// Scoreboard bench for mod_inv: a Fermat-exponentiation reference model predicts
// each inverse, and a negedge monitor checks every done pulse against the queue.
module tb_mod_inv;

  localparam logic [255:0] P = 256'hFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFEFFFFFC2F;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [255:0] A = '0;
  logic [255:0] R;
  logic         done;
  logic         busy;
  logic         err;

  mod_inv #(.P(P), .MAX_CYCLES(1100)) dut (
    .clk  (clk),
    .rst  (rst),
    .start(start),
    .A    (A),
    .R    (R),
    .done (done),
    .busy (busy),
    .err  (err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  typedef struct {
    logic [255:0] a;
    logic [255:0] exp_r;
    logic         exp_err;
    int           start_cyc;
    int           exact_lat;
  } txn_t;

  txn_t sb[$];
  int n_cmp  = 0;
  int n_bad  = 0;
  int n_done = 0;

  function automatic logic [255:0] mulmod(input logic [255:0] x, input logic [255:0] y);
    logic [511:0] prod;
    prod = {256'd0, x} * {256'd0, y};
    return 256'(prod % {256'd0, P});
  endfunction

  // Inverse via Fermat's little theorem: a^(P-2) mod P.
  function automatic logic [255:0] ref_inv(input logic [255:0] a);
    logic [255:0] base;
    logic [255:0] r;
    logic [255:0] e;
    base = a % P;
    if (base == '0) return '0;
    r = 256'd1;
    e = P - 256'd2;
    for (int i = 0; i < 256; i++) begin
      if (e[i]) r = mulmod(r, base);
      base = mulmod(base, base);
    end
    return r;
  endfunction

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    txn_t t;
    if (!rst && done) begin
      n_done++;
      check("busy_low_with_done", 256'(busy), 256'd0);
      if (sb.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_done: got done with empty scoreboard, required none");
      end else begin
        t = sb.pop_front();
        check("R", R, t.exp_r);
        check("err", 256'(err), 256'(t.exp_err));
        if (!t.exp_err) check("roundtrip", mulmod(t.a, R), 256'd1);
        if (t.exact_lat >= 0)
          check("latency_exact", 256'(cyc - t.start_cyc), 256'(t.exact_lat));
        else
          check("latency_bound", 256'((cyc - t.start_cyc) <= 1026), 256'd1);
      end
    end
  end

  task automatic issue(input logic [255:0] a, input int exact);
    txn_t t;
    @(negedge clk);
    start = 1'b1;
    A     = a;
    @(posedge clk);
    #1;
    start       = 1'b0;
    t.a         = a;
    t.exp_r     = ref_inv(a);
    t.exp_err   = ((a % P) == '0);
    t.start_cyc = cyc;
    t.exact_lat = exact;
    sb.push_back(t);
  endtask

  task automatic wait_done(input int prev);
    int k;
    k = 0;
    while (n_done == prev && k < 1100) begin
      @(posedge clk);
      k++;
    end
    if (n_done == prev) begin
      n_cmp++;
      n_bad++;
      $display("FAIL done_timeout: got no done after %0d cycles, required done", k);
      sb.delete();
    end
  endtask

  task automatic run(input logic [255:0] a, input int exact);
    int p;
    p = n_done;
    issue(a, exact);
    wait_done(p);
  endtask

  initial begin
    logic [255:0] a;
    logic [255:0] top_bit;
    logic [256:0] half_p1;
    logic [257:0] third;
    int p;
    int k;

    repeat (3) @(posedge clk);
    #1;
    check("reset_R", R, '0);
    check("reset_done", 256'(done), 256'd0);
    check("reset_busy", 256'(busy), 256'd0);
    check("reset_err", 256'(err), 256'd0);
    @(negedge clk);
    rst = 1'b0;

    // Directed values and field boundaries.
    run(256'd1, 3);
    half_p1 = ({1'b0, P} + 257'd1) >> 1;
    run(256'd2, -1);
    check("A2_half", R, half_p1[255:0]);
    run(P - 256'd1, -1);
    check("Pm1_self", R, P - 256'd1);
    run(256'd0, -1);
    run(P, -1);
    run(P + 256'd1, -1);
    check("Pp1_reduce", R, 256'd1);
    run(P - 256'd2, -1);
    run(256'h12345, -1);
    top_bit = 256'd1 << 255;
    run(top_bit, -1);

    for (int i = 0; i < 120; i++) begin
      a = {$urandom(), $urandom(), $urandom(), $urandom(),
           $urandom(), $urandom(), $urandom(), $urandom()};
      run(a, -1);
    end

    // Starts while busy (and during the done cycle) must be ignored.
    p = n_done;
    issue(256'h1D2C3B4A5968778695A4B3C2D1E0F00112233445566778899AABBCCDDEEFF001, -1);
    k = 0;
    while (k < 1100) begin
      @(negedge clk);
      if (done) break;
      start = 1'b1;
      A     = {$urandom(), $urandom(), $urandom(), $urandom(),
               $urandom(), $urandom(), $urandom(), $urandom()};
      k++;
    end
    @(posedge clk);
    #1;
    start = 1'b0;
    check("start_in_done_cycle_ignored", 256'(busy), 256'd0);
    repeat (5) @(posedge clk);
    check("single_done_pulse", 256'(n_done - p), 256'd1);

    // Asynchronous reset in the middle of a long LOOP phase.
    issue(256'hC0FFEE0123456789ABCDEF0FEDCBA9876543210DEADBEEFCAFEBABE13579BDF1, -1);
    repeat (100) @(posedge clk);
    #2;
    check("busy_before_reset", 256'(busy), 256'd1);
    rst = 1'b1;
    #1;
    sb.delete();
    check("midrst_R", R, '0);
    check("midrst_done", 256'(done), 256'd0);
    check("midrst_busy", 256'(busy), 256'd0);
    check("midrst_err", 256'(err), 256'd0);
    @(negedge clk);
    rst = 1'b0;
    third = ({2'b0, P} * 258'd2 + 258'd1) / 258'd3;
    run(256'd3, -1);
    check("A3_after_reset", R, third[255:0]);
    check("A3_err", 256'(err), 256'd0);

    repeat (3) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL global_timeout: got simulation still running, required completion");
    $fatal(1, "global timeout");
  end

endmodule
